// File: rtl/scan_frame_sequencer_if.sv
// scan_frame_sequencer_if: control, configuration and pixel-strobe signals of the frame sequencer
interface scan_frame_sequencer_if #(parameter int IDX_W = 16);
  logic             start;
  logic             stop;
  logic             cont_en;
  logic [2:0]       source_choose;
  logic [15:0]      framedat_length;
  logic [15:0]      trace_length;
  logic [15:0]      retrace_length;
  logic             pix_ready;
  logic             pix_valid;
  logic [2:0]       source_sel;
  logic [IDX_W-1:0] line_idx;
  logic [IDX_W-1:0] pix_idx;
  logic             in_retrace;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
  logic             cfg_err;
  modport master (
    output start, stop, cont_en, source_choose, framedat_length, trace_length, retrace_length, pix_ready,
    input  pix_valid, source_sel, line_idx, pix_idx, in_retrace, frame_start, frame_done, busy, cfg_err
  );
  modport slave (
    input  start, stop, cont_en, source_choose, framedat_length, trace_length, retrace_length, pix_ready,
    output pix_valid, source_sel, line_idx, pix_idx, in_retrace, frame_start, frame_done, busy, cfg_err
  );
endinterface

// File: rtl/scan_frame_sequencer.sv
// scan_frame_sequencer: sequences one scan frame of trace/retrace lines from shadowed configuration
module scan_frame_sequencer #(
  parameter bit CONT_DEFAULT = 1'b0,
  parameter int IDX_W        = 16
) (
  input logic                  clk,
  input logic                  reset,
  scan_frame_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, TRACE, RETRACE, EOL, DONE} state_t;
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  state_t           state;
  logic [IDX_W-1:0] sh_lines;
  logic [IDX_W-1:0] sh_trace;
  logic [IDX_W-1:0] sh_retrace;
  logic [IDX_W-1:0] rcnt;
  logic             bad_cfg;
  logic             cont_on;
  logic             rearm;
  logic             load_now;
  logic             reject;
  assign bad_cfg  = bus.framedat_length == '0 || (bus.trace_length == '0 && bus.retrace_length == '0);
  assign cont_on  = bus.cont_en | CONT_DEFAULT;
  assign rearm    = (state == IDLE && bus.start) || (state == DONE && cont_on && !bus.stop);
  assign load_now = rearm && !bad_cfg;
  assign reject   = rearm && bad_cfg;
  // Frame FSM; every output is a register updated alongside the state it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sh_lines        <= '0;
      sh_trace        <= '0;
      sh_retrace      <= '0;
      rcnt            <= '0;
      bus.pix_valid   <= 1'b0;
      bus.source_sel  <= '0;
      bus.line_idx    <= '0;
      bus.pix_idx     <= '0;
      bus.in_retrace  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.cfg_err     <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.cfg_err     <= reject;
      case (state)
        IDLE: ;
        LOAD: begin
          if (sh_trace != '0) begin
            state         <= TRACE;
            bus.pix_valid <= 1'b1;
          end else begin
            state          <= RETRACE;
            bus.in_retrace <= 1'b1;
            rcnt           <= '0;
          end
        end
        TRACE: begin
          if (bus.pix_ready) begin
            if (bus.pix_idx == sh_trace - ONE) begin
              bus.pix_idx   <= '0;
              bus.pix_valid <= 1'b0;
              if (sh_retrace != '0) begin
                state          <= RETRACE;
                bus.in_retrace <= 1'b1;
                rcnt           <= '0;
              end else begin
                state <= EOL;
              end
            end else begin
              bus.pix_idx <= bus.pix_idx + ONE;
            end
          end
        end
        RETRACE: begin
          if (rcnt == sh_retrace - ONE) begin
            state          <= EOL;
            bus.in_retrace <= 1'b0;
          end else begin
            rcnt <= rcnt + ONE;
          end
        end
        EOL: begin
          if (bus.line_idx == sh_lines - ONE || bus.stop) begin
            state          <= DONE;
            bus.frame_done <= 1'b1;
          end else begin
            bus.line_idx <= bus.line_idx + ONE;
            if (sh_trace != '0) begin
              state         <= TRACE;
              bus.pix_valid <= 1'b1;
            end else begin
              state          <= RETRACE;
              bus.in_retrace <= 1'b1;
              rcnt           <= '0;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (load_now) begin
        state           <= LOAD;
        sh_lines        <= IDX_W'(bus.framedat_length);
        sh_trace        <= IDX_W'(bus.trace_length);
        sh_retrace      <= IDX_W'(bus.retrace_length);
        bus.source_sel  <= bus.source_choose;
        bus.frame_start <= 1'b1;
        bus.busy        <= 1'b1;
        bus.line_idx    <= '0;
        bus.pix_idx     <= '0;
        bus.pix_valid   <= 1'b0;
        bus.in_retrace  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_scan_frame_sequencer.sv
// tb_scan_frame_sequencer: randomized and directed checks against a slot-queue frame model
module tb_scan_frame_sequencer;
  localparam bit CONT_DEF = 1'b0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  scan_frame_sequencer_if #(.IDX_W(16)) bus ();
  scan_frame_sequencer #(.CONT_DEFAULT(CONT_DEF), .IDX_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef enum int {K_LOAD, K_PIX, K_RET, K_EOL, K_DONE} kind_t;
  typedef struct {kind_t kind; int line; int pix;} slot_t;
  slot_t q[$];
  slot_t m_s;
  int m_line = 0, m_pix = 0;
  logic [2:0] m_src = 3'd0;
  logic m_cfg_err = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int cyc_no = 0, start_cyc = 0, fs_cnt = 0, fd_cnt = 0, last_fs = 0, last_fd = 0, first_pv = 0;
  int xfer_total = 0, frame_xfer = 0, last_frame_xfer = 0, ret_total = 0, pv_total = 0, cfg_cnt = 0, last_done_line = 0;
  bit pv_seen = 1'b0;
  function automatic bit bad_cfg(input int l, input int t, input int r);
    return l == 0 || (t == 0 && r == 0);
  endfunction
  // A frame is a flat list of one-cycle slots; pixel slots retire only on a transfer
  task automatic build(input int l, input int t, input int r);
    q.push_back(slot_t'{K_LOAD, 0, 0});
    for (int i = 0; i < l; i++) begin
      for (int p = 0; p < t; p++) q.push_back(slot_t'{K_PIX, i, p});
      for (int k = 0; k < r; k++) q.push_back(slot_t'{K_RET, i, 0});
      q.push_back(slot_t'{K_EOL, i, 0});
    end
    q.push_back(slot_t'{K_DONE, l - 1, 0});
  endtask
  task automatic try_load();
    if (bad_cfg(int'(bus.framedat_length), int'(bus.trace_length), int'(bus.retrace_length))) m_cfg_err = 1'b1;
    else begin
      build(int'(bus.framedat_length), int'(bus.trace_length), int'(bus.retrace_length));
      m_src = bus.source_choose;
    end
  endtask
  // Reference model: advance the slot list once per clock
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_line = 0; m_pix = 0; m_src = 3'd0; m_cfg_err = 1'b0;
    end else begin
      m_cfg_err = 1'b0;
      if (q.size() == 0) begin
        if (bus.start) try_load();
      end else begin
        m_s = q[0];
        case (m_s.kind)
          K_PIX: if (bus.pix_ready) void'(q.pop_front());
          K_EOL: begin
            if (bus.stop) begin
              m_s = q[q.size() - 1];
              m_s.line = q[0].line;
              q.delete();
              q.push_back(m_s);
            end else void'(q.pop_front());
          end
          K_DONE: begin
            void'(q.pop_front());
            if ((bus.cont_en || CONT_DEF) && !bus.stop) try_load();
          end
          default: void'(q.pop_front());
        endcase
      end
      if (q.size() != 0) begin
        m_line = q[0].line;
        m_pix = q[0].pix;
      end
    end
  end
  // Event counters used by the directed checks
  always @(negedge clk) begin
    cyc_no++;
    if (!reset) begin
      if (bus.start) start_cyc = cyc_no;
      if (bus.frame_start) begin
        fs_cnt++; last_fs = cyc_no; frame_xfer = 0; pv_seen = 1'b0;
      end
      if (bus.pix_valid) pv_total++;
      if (bus.pix_valid && !pv_seen) begin
        first_pv = cyc_no; pv_seen = 1'b1;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        xfer_total++; frame_xfer++;
      end
      if (bus.in_retrace) ret_total++;
      if (bus.cfg_err) cfg_cnt++;
      if (bus.frame_done) begin
        fd_cnt++; last_fd = cyc_no; last_frame_xfer = frame_xfer; last_done_line = int'(bus.line_idx);
      end
    end
  end
  function automatic bit differ(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, got, want, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction
  task automatic compare_all();
    bit e_busy, e_pv, e_ret, e_fs, e_fd, bad;
    e_busy = q.size() != 0;
    e_pv = e_busy && q[0].kind == K_PIX;
    e_ret = e_busy && q[0].kind == K_RET;
    e_fs = e_busy && q[0].kind == K_LOAD;
    e_fd = e_busy && q[0].kind == K_DONE;
    bad = 1'b0;
    bad |= differ("busy", 32'(bus.busy), 32'(e_busy));
    bad |= differ("pix_valid", 32'(bus.pix_valid), 32'(e_pv));
    bad |= differ("in_retrace", 32'(bus.in_retrace), 32'(e_ret));
    bad |= differ("frame_start", 32'(bus.frame_start), 32'(e_fs));
    bad |= differ("frame_done", 32'(bus.frame_done), 32'(e_fd));
    bad |= differ("cfg_err", 32'(bus.cfg_err), 32'(m_cfg_err));
    bad |= differ("source_sel", 32'(bus.source_sel), 32'(m_src));
    bad |= differ("line_idx", 32'(bus.line_idx), m_line);
    bad |= differ("pix_idx", 32'(bus.pix_idx), m_pix);
    n_cmp++;
    if (bad) n_bad++;
  endtask
  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!reset) compare_all();
      @(posedge clk);
      #2;
    end
  endtask
  task automatic drive_ready(input int mode);
    bus.pix_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.pix_ready : 1'($urandom);
  endtask
  task automatic wait_idle(input int limit, input int mode);
    int k = 0;
    while (bus.busy && k < limit) begin
      drive_ready(mode);
      cyc(1);
      k++;
    end
    if (bus.busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", limit);
    end
    bus.pix_ready = 1'b1;
  endtask
  task automatic start_frame(input int src, input int l, input int t, input int r);
    bus.source_choose = 3'(src);
    bus.framedat_length = 16'(l);
    bus.trace_length = 16'(t);
    bus.retrace_length = 16'(r);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask
  task automatic wait_count(input string nm, input int which, input int target);
    int k = 0;
    while ((which == 0 ? fs_cnt : fd_cnt) < target && k < 500) begin
      cyc(1);
      k++;
    end
    if (k >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: event count did not reach %0d", nm, target);
    end
  endtask
  initial begin
    int sx, sr, sp, c, f, s, k;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cont_en = 1'b0; bus.pix_ready = 1'b1;
    bus.source_choose = 3'd0; bus.framedat_length = 16'd0; bus.trace_length = 16'd0; bus.retrace_length = 16'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_line", int'(bus.line_idx), 0);
    check("rst_src", int'(bus.source_sel), 0);
    cyc(2);
    sx = xfer_total; sr = ret_total;
    start_frame(5, 3, 4, 2);
    wait_idle(100, 0);
    check("basic_fs_latency", last_fs - start_cyc, 1);
    check("basic_pv_latency", first_pv - start_cyc, 2);
    check("basic_frame_len", last_fd - last_fs + 1, 23);
    check("basic_xfers", xfer_total - sx, 12);
    check("basic_retrace", ret_total - sr, 6);
    check("basic_src", int'(bus.source_sel), 5);
    check("basic_busy_after", int'(bus.busy), 0);
    sx = xfer_total; sr = ret_total;
    start_frame(5, 3, 4, 2);
    wait_idle(200, 1);
    check("bp_xfers", xfer_total - sx, 12);
    check("bp_retrace", ret_total - sr, 6);
    sx = xfer_total; sp = pv_total;
    start_frame(1, 2, 0, 3);
    wait_idle(100, 0);
    check("zt_frame_len", last_fd - last_fs + 1, 10);
    check("zt_pv_cycles", pv_total - sp, 0);
    c = cfg_cnt; s = fs_cnt;
    start_frame(2, 0, 4, 2);
    cyc(2);
    check("zl_cfg_err", cfg_cnt - c, 1);
    check("zl_busy", int'(bus.busy), 0);
    start_frame(2, 3, 0, 0);
    cyc(2);
    check("zz_cfg_err", cfg_cnt - c, 2);
    check("zz_no_frame", fs_cnt - s, 0);
    bus.cont_en = 1'b1;
    f = fd_cnt; s = fs_cnt;
    start_frame(3, 2, 4, 1);
    cyc(3);
    bus.trace_length = 16'd6;
    wait_count("cont_f1", 1, f + 1);
    check("cont_f1_xfers", last_frame_xfer, 8);
    wait_count("cont_f2", 1, f + 2);
    check("cont_f2_xfers", last_frame_xfer, 12);
    wait_count("cont_f3", 0, s + 3);
    check("cont_restart_gap", last_fs - last_fd, 1);
    cyc(2);
    bus.stop = 1'b1;
    wait_idle(100, 0);
    bus.stop = 1'b0;
    bus.cont_en = 1'b0;
    check("stop_done_line", last_done_line, 0);
    check("stop_xfers", last_frame_xfer, 6);
    check("stop_frames", fd_cnt - f, 3);
    f = fd_cnt;
    start_frame(4, 2, 6, 1);
    k = 0;
    while (bus.pix_idx != 16'd2 && k < 50) begin
      cyc(1);
      k++;
    end
    check("rst_reach_pix2", int'(bus.pix_idx), 2);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_pix_valid", int'(bus.pix_valid), 0);
    check("arst_pix_idx", int'(bus.pix_idx), 0);
    check("arst_line_idx", int'(bus.line_idx), 0);
    check("arst_src", int'(bus.source_sel), 0);
    check("arst_retrace", int'(bus.in_retrace), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    cyc(1);
    check("arst_no_done", fd_cnt - f, 0);
    sx = xfer_total;
    start_frame(6, 2, 3, 2);
    wait_idle(100, 0);
    check("arst_clean_xfers", xfer_total - sx, 6);
    check("arst_clean_len", last_fd - last_fs + 1, 14);
    c = cfg_cnt; s = fs_cnt; sx = xfer_total;
    start_frame(1, 2, 3, 1);
    bus.framedat_length = 16'd0;
    k = 0;
    while (bus.busy && k < 100) begin
      bus.start = k[0] ? 1'b0 : 1'b1;
      cyc(1);
      k++;
    end
    bus.start = 1'b0;
    check("ign_cfg_err", cfg_cnt - c, 0);
    check("ign_frames", fs_cnt - s, 1);
    check("ign_xfers", xfer_total - sx, 6);
    check("ign_len", last_fd - last_fs + 1, 12);
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom % 8) == 0;
      bus.stop = ($urandom % 16) == 0;
      bus.cont_en = ($urandom % 4) == 0;
      bus.source_choose = 3'($urandom);
      bus.framedat_length = 16'($urandom_range(0, 3));
      bus.trace_length = 16'($urandom_range(0, 5));
      bus.retrace_length = 16'($urandom_range(0, 3));
      bus.pix_ready = 1'($urandom);
      cyc(1);
    end
    bus.start = 1'b0; bus.stop = 1'b1; bus.cont_en = 1'b0;
    wait_idle(200, 2);
    bus.stop = 1'b0;
    cyc(2);
    sx = xfer_total;
    start_frame(7, 1, 16'hFFFF, 1);
    wait_idle(70000, 0);
    check("max_xfers", xfer_total - sx, 65535);
    check("max_len", last_fd - last_fs + 1, 65539);
    check("max_done_line", last_done_line, 0);
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scan_frame_sequencer.md
Name: scan_frame_sequencer

Overview:
- Sequences one scan frame using the configuration registered by the frame-setting stage: source select, lines per frame, trace length and retrace length.
- Each line is a trace phase that emits pixel strobes with downstream backpressure, followed by a fixed retrace phase that ignores backpressure.
- The block sits between the frame-setting register stage and the pixel datapath/DMA.
- It produces busy, line and pixel indices, frame-boundary pulses and a latched source select.

Parameters:
- CONT_DEFAULT, 0, reset value of continuous mode: 1 re-arms a new frame automatically after frame_done.
- IDX_W, 16, width of the line and pixel index outputs and of the internal counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  input  1  level; ends the frame at the next line boundary.
- cont_en  input  1  continuous mode enable, sampled at frame end.
- source_choose  input  3  source select, captured at frame start.
- framedat_length  input  16  lines per frame.
- trace_length  input  16  pixels per trace phase.
- retrace_length  input  16  idle cycles per retrace phase.
- pix_ready  input  1  downstream ready.
- pix_valid  output  1  pixel strobe; a pixel transfers on a cycle where pix_valid and pix_ready are both 1.
- source_sel  output  3  latched source select.
- line_idx  output  16  current line, 0-based.
- pix_idx  output  16  current pixel within the trace, 0-based.
- in_retrace  output  1  high during the retrace phase.
- frame_start  output  1  one-cycle pulse on the first cycle out of IDLE.
- frame_done  output  1  one-cycle pulse when the frame ends.
- busy  output  1  high in any state other than IDLE.
- cfg_err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and cont_en's internal default is CONT_DEFAULT (cont_en input ORed with it).
- Reset asserted mid-frame aborts immediately. No frame_done is emitted.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle):
    - Captures all four config inputs into shadow registers; source_sel updates from the shadow in this state.
    - Pulses frame_start, clears line_idx and pix_idx, sets busy.
    - Next state is TRACE if shadow trace_length != 0, otherwise RETRACE.
  - TRACE:
    - pix_valid=1.
    - On a transfer, pix_idx increments. When the transfer is at pix_idx = trace_length-1, the next state is RETRACE (or EOL if retrace_length=0) and pix_idx is cleared.
    - When pix_ready=0, pix_valid stays 1 and pix_idx holds.
  - RETRACE:
    - in_retrace=1, pix_valid=0.
    - Counts retrace_length cycles, independent of pix_ready, then goes to EOL.
  - EOL (1 cycle):
    - If line_idx = framedat_length-1 or stop=1: go to DONE.
    - Otherwise: line_idx+1, go to TRACE (or RETRACE if trace_length=0).
  - DONE (1 cycle):
    - Pulses frame_done.
    - If cont_en=1 and stop=0: go to LOAD, which recaptures config.
    - Otherwise: go to IDLE, clear busy.
- Latency: start -> frame_start pulse is 1 cycle; start -> first pix_valid is 2 cycles.
- Rejected start:
  - start in IDLE with framedat_length=0, or with trace_length=0 and retrace_length=0, pulses cfg_err on the next cycle. The state remains IDLE.
  - In continuous mode the same check is applied in DONE; a failure pulses cfg_err and goes to IDLE.
- start while busy is ignored.
- Config inputs are ignored outside LOAD, so mid-frame changes do not take effect until the next frame.
- stop is sampled only in EOL and DONE. Once asserted, the current trace always completes fully, i.e. line_idx is never truncated within a line.
- Counters are IDX_W bits and compare for equality against length-1. A 16'hFFFF length is legal (65535 counts); no wrap occurs before the terminal count.
- Counts:
  - Full frame with no stalls: framedat_length × (trace_length + retrace_length + 1) + 2 cycles from LOAD through DONE.
  - Pixels per frame: exactly framedat_length × trace_length.

Test Plan:
- Basic frame, cont_en=0:
  - Stimulus: framedat=3, trace=4, retrace=2, source=5, pix_ready=1, start pulse.
  - Response: frame_start 1 cycle after start; 12 pixels; pix_idx 0..3 per line; line_idx 0..2; in_retrace high 2 cycles per line; source_sel=5.
  - Response: frame_done exactly 3×7+2=23 cycles after frame_start (LOAD through DONE); busy then drops.
- Backpressure:
  - Stimulus: same config; pix_ready toggles 1,0,1,0.
  - Response: pix_valid held high through stalls; pix_idx held during stalls; exactly 12 transfers; retrace length unaffected.
- Zero lengths:
  - Stimulus: trace=0, retrace=3, framedat=2.
  - Response: no pix_valid; frame of 2×4+2 cycles.
  - Stimulus: framedat=0 with start.
  - Response: cfg_err pulse; busy stays 0.
- Continuous mode and stop:
  - Stimulus: cont_en=1, framedat=2; change trace 4->6 mid-frame.
  - Response: second frame uses trace=6; frame_start follows frame_done by 1 cycle.
  - Stimulus: assert stop during line 0 of the third frame.
  - Response: line 0 completes, then frame_done, then IDLE.
- Async reset mid-trace:
  - Stimulus: reset asserted at pix_idx=2.
  - Response: all outputs 0 within the same cycle with no clock edge; no frame_done; a subsequent start runs a clean frame.
- Ignored start:
  - Stimulus: start pulses while busy.
  - Response: no effect on counters or state; no cfg_err.
